// File: rtl/mul_acc_pkg.sv
// Shared types and default constants for the product accumulator.
package mul_acc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam int DEF_SIZE       = 8;
  localparam int DEF_DOT_LEN    = 4;
  localparam int DEF_ACC_W      = 18;
  localparam int DEF_FIFO_DEPTH = 4;

endpackage

// File: rtl/mul_acc_fifo.sv
// Synchronous product buffer; DEPTH must be a power of two >= 2 so pointers wrap naturally.
module mul_acc_fifo #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         srst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nx_s;
  logic             full_r;

  // Occupancy after this edge; push/pop are already qualified by the caller.
  always_comb begin
    count_nx_s = count_r;
    case ({push, pop})
      2'b10:   count_nx_s = count_r + CNT_W'(1);
      2'b01:   count_nx_s = count_r - CNT_W'(1);
      default: count_nx_s = count_r;
    endcase
  end

  // Storage array, not reset.
  always_ff @(posedge clk) begin
    if (push && !srst) begin
      mem[wr_ptr_r] <= din;
    end
  end

  // Pointers, occupancy and registered full flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
    end else if (srst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
    end else begin
      if (push) wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      if (pop)  rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      count_r <= count_nx_s;
      full_r  <= (count_nx_s == CNT_W'(DEPTH));
    end
  end

  assign dout  = mem[rd_ptr_r];
  assign empty = (count_r == '0);
  assign full  = full_r;

endmodule

// File: rtl/mul_acc_8bit.sv
// Buffers multiplier products and sums DOT_LEN of them per result with a valid/ready output.
// Optional macro MUL_ACC_DROP_CNT_EN adds a saturating dropped-product counter output.
module mul_acc_8bit
  import mul_acc_pkg::*;
#(
  parameter int size       = DEF_SIZE,
  parameter int DOT_LEN    = DEF_DOT_LEN,
  parameter int ACC_W      = DEF_ACC_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prod_en_in,
  input  logic [2*size-1:0] prod_in,
  input  logic              clr,
  input  logic              acc_ready,
  output logic              acc_valid,
  output logic [ACC_W-1:0]  acc_out,
  output logic              fifo_full,
  output logic              ovf_flag
`ifdef MUL_ACC_DROP_CNT_EN
  ,
  output logic [7:0]        drop_cnt
`endif
);

  localparam int CNT_W = $clog2(DOT_LEN);

  state_t            state_r, state_nx_s;
  logic [CNT_W-1:0]  cnt_r;
  logic [ACC_W-1:0]  acc_r;
  logic [ACC_W-1:0]  acc_out_r;
  logic [ACC_W-1:0]  sum_s;
  logic              acc_valid_r;
  logic              ovf_r;
  logic [2*size-1:0] fifo_dout_s;
  logic              fifo_empty_s;
  logic              fifo_full_s;
  logic              pop_s, push_s, drop_s, last_s;

  // A full buffer still accepts a product when an entry leaves on the same edge.
  assign pop_s  = !clr && !fifo_empty_s && (state_r != HOLD);
  assign push_s = !clr && prod_en_in && (!fifo_full_s || pop_s);
  assign drop_s = !clr && prod_en_in && fifo_full_s && !pop_s;
  assign last_s = pop_s && (cnt_r == CNT_W'(DOT_LEN - 1));
  assign sum_s  = acc_r + ACC_W'(fifo_dout_s);

  mul_acc_fifo #(
    .W     (2*size),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .srst  (clr),
    .push  (push_s),
    .pop   (pop_s),
    .din   (prod_in),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (pop_s) state_nx_s = last_s ? HOLD : ACCUM;
        else       state_nx_s = IDLE;
      end
      ACCUM: begin
        if (last_s) state_nx_s = HOLD;
        else        state_nx_s = ACCUM;
      end
      HOLD: begin
        if (acc_ready) state_nx_s = IDLE;
        else           state_nx_s = HOLD;
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State, accumulator and registered outputs; clr outranks every other update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      acc_r       <= '0;
      acc_out_r   <= '0;
      acc_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
    end else if (clr) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      acc_r       <= '0;
      acc_out_r   <= '0;
      acc_valid_r <= 1'b0;
      ovf_r       <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      if (last_s) begin
        acc_out_r   <= sum_s;
        acc_valid_r <= 1'b1;
        acc_r       <= '0;
        cnt_r       <= '0;
      end else if (pop_s) begin
        acc_r <= sum_s;
        cnt_r <= cnt_r + CNT_W'(1);
      end
      if ((state_r == HOLD) && acc_ready) acc_valid_r <= 1'b0;
      if (drop_s) ovf_r <= 1'b1;
    end
  end

`ifdef MUL_ACC_DROP_CNT_EN
  logic [7:0] drop_cnt_r;

  // Dropped-product counter, saturating at 255.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_r <= 8'd0;
    end else if (clr) begin
      drop_cnt_r <= 8'd0;
    end else if (drop_s && (drop_cnt_r != 8'd255)) begin
      drop_cnt_r <= drop_cnt_r + 8'd1;
    end
  end

  assign drop_cnt = drop_cnt_r;
`endif

  assign acc_valid = acc_valid_r;
  assign acc_out   = acc_out_r;
  assign fifo_full = fifo_full_s;
  assign ovf_flag  = ovf_r;

endmodule

// File: tb/tb_mul_acc_8bit.sv
// Self-checking bench for mul_acc_8bit: vector table plus hand-written corner sequences.
module tb_mul_acc_8bit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        prod_en_in = 1'b0;
  logic [15:0] prod_in = 16'd0;
  logic        clr = 1'b0;
  logic        acc_ready = 1'b1;
  logic        acc_valid;
  logic [17:0] acc_out;
  logic        fifo_full;
  logic        ovf_flag;
`ifdef MUL_ACC_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int checks = 0;
  int failures = 0;
  logic [17:0] exp_q[$];

  typedef struct packed {
    logic [3:0][15:0] p;
    logic [17:0]      exp;
  } vec_t;
  vec_t vecs[5];

  mul_acc_8bit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prod_en_in (prod_en_in),
    .prod_in    (prod_in),
    .clr        (clr),
    .acc_ready  (acc_ready),
    .acc_valid  (acc_valid),
    .acc_out    (acc_out),
    .fifo_full  (fifo_full),
    .ovf_flag   (ovf_flag)
`ifdef MUL_ACC_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Scoreboard: every accepted result must match the oldest expected value.
  always @(negedge clk) begin
    if (rst_n && acc_valid && acc_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_result actual=%0d required=none", acc_out);
      end else begin
        check("result", acc_out, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [15:0] v);
    prod_en_in = 1'b1;
    prod_in    = v;
    tick();
    prod_en_in = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
    check("drain_left", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    vecs[0].p = {16'd9, 16'd7, 16'd5, 16'd3};             vecs[0].exp = 18'd24;
    vecs[1].p = {16'd65025, 16'd65025, 16'd65025, 16'd65025}; vecs[1].exp = 18'd260100;
    vecs[2].p = {16'd0, 16'd0, 16'd0, 16'd0};             vecs[2].exp = 18'd0;
    vecs[3].p = {16'd4, 16'd3, 16'd2, 16'd1};             vecs[3].exp = 18'd10;
    vecs[4].p = {16'd65535, 16'd65535, 16'd65535, 16'd65535}; vecs[4].exp = 18'd262140;

    // Reset state
    repeat (2) tick();
    check("rst_acc_valid", acc_valid, 0);
    check("rst_acc_out", acc_out, 0);
    check("rst_fifo_full", fifo_full, 0);
    check("rst_ovf_flag", ovf_flag, 0);
    rst_n = 1'b1;
    tick();

    // Table vectors with latency and single-cycle valid checks
    for (int v = 0; v < 5; v++) begin
      exp_q.push_back(vecs[v].exp);
      for (int j = 0; j < 4; j++) drive(vecs[v].p[j]);
      check("lat_edge_k", acc_valid, 0);
      tick();
      check("lat_edge_k1", acc_valid, 1);
      check("lat_value", acc_out, vecs[v].exp);
      tick();
      check("valid_one_cycle", acc_valid, 0);
      drain();
    end

    // Backpressure: 6 products while held, 4 buffered, 2 dropped
    acc_ready = 1'b0;
    exp_q.push_back(18'd10);
    exp_q.push_back(18'd100);
    for (int j = 1; j <= 4; j++) drive(16'(j));
    for (int i = 0; i < 10; i++) begin
      if (i < 6) drive(16'(10 * (i + 1)));
      else       tick();
      check("hold_valid", acc_valid, 1);
      check("hold_out", acc_out, 10);
    end
    check("bp_fifo_full", fifo_full, 1);
    check("bp_ovf_flag", ovf_flag, 1);
`ifdef MUL_ACC_DROP_CNT_EN
    check("bp_drop_cnt", drop_cnt, 2);
`endif
    acc_ready = 1'b1;
    drain();
    check("ovf_sticky", ovf_flag, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("clr_ovf_flag", ovf_flag, 0);
    check("clr_fifo_full", fifo_full, 0);
`ifdef MUL_ACC_DROP_CNT_EN
    check("clr_drop_cnt", drop_cnt, 0);
`endif

    // Push while full with a simultaneous pop
    acc_ready = 1'b0;
    exp_q.push_back(18'd4);
    exp_q.push_back(18'd8);
    exp_q.push_back(18'd20);
    repeat (4) drive(16'd1);
    repeat (4) drive(16'd2);
    check("full_before", fifo_full, 1);
    acc_ready = 1'b1;
    tick();
    drive(16'd5);
    check("full_pushpop", fifo_full, 1);
    check("ovf_pushpop", ovf_flag, 0);
    repeat (3) drive(16'd5);
    drain();
    check("ovf_after_pushpop", ovf_flag, 0);

    // Reset mid-accumulation discards the partial sum
    drive(16'd7);
    drive(16'd7);
    rst_n = 1'b0;
    #2;
    check("midrst_acc_valid", acc_valid, 0);
    check("midrst_acc_out", acc_out, 0);
    rst_n = 1'b1;
    exp_q.push_back(18'd4);
    repeat (4) drive(16'd1);
    drain();

    // clr in HOLD with 3 buffered products; the product on the clr edge is discarded
    acc_ready = 1'b0;
    repeat (4) drive(16'd3);
    repeat (3) drive(16'd3);
    check("hold_before_clr", acc_valid, 1);
    clr = 1'b1;
    prod_en_in = 1'b1;
    prod_in = 16'd100;
    tick();
    clr = 1'b0;
    prod_en_in = 1'b0;
    check("clr_hold_valid", acc_valid, 0);
    check("clr_hold_out", acc_out, 0);
    check("clr_hold_full", fifo_full, 0);
    check("clr_hold_ovf", ovf_flag, 0);
    repeat (3) tick();
    check("clr_fifo_empty", acc_valid, 0);
    acc_ready = 1'b1;
    exp_q.push_back(18'd8);
    repeat (4) drive(16'd2);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
